// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
// Optional match counter: define SEQ_DET_MATCH_CNT_EN.
package seq_det_pkg;

    // Width needed to hold a length value in the range 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    localparam int          DEF_MAX_LEN = 8;
    localparam logic [31:0] DEF_PATTERN = 32'h0000_0006;
    localparam int          DEF_LEN     = 3;

endpackage

// File: rtl/seq_det_hist.sv
// Bit history shift register (newest bit at LSB) with a fill counter that saturates at MAX_LEN.
// Exposes the post-shift view so the caller can evaluate a match on the same edge.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    localparam int LEN_W  = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_i,
    input  logic               clr_i,
    input  logic               bit_i,
    output logic [MAX_LEN-1:0] hist_o,
    output logic [LEN_W-1:0]   fill_o,
    output logic [MAX_LEN-1:0] shift_hist_o,
    output logic [LEN_W-1:0]   shift_fill_o
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    assign shift_hist_o = {hist_q[MAX_LEN-2:0], bit_i};
    assign shift_fill_o = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);

    // Clear wins over shift: a config load or non-overlap match discards the incoming bit's history.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = shift_hist_o;
            fill_d = shift_fill_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist_o = hist_q;
    assign fill_o = fill_q;

endmodule

// File: rtl/seq_det_param.sv
// Run-time programmable serial sequence detector with registered single-cycle match pulse z.
// Optional saturating match counter on port match_cnt: define SEQ_DET_MATCH_CNT_EN.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int                 RST_LEN     = DEF_LEN,
    parameter logic               RST_OVERLAP = OVL_ON,
    parameter int                 CNT_W       = 16,
    localparam int                LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    // A bit is consumed on every edge with in_valid=1; there is no back-pressure.
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef SEQ_DET_MATCH_CNT_EN
    output logic [CNT_W-1:0]   match_cnt,
`endif
    output logic               z,
    output logic               armed
);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l <= LEN_W'(1))
            return LEN_W'(1);
        else if (l > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        else
            return l;
    endfunction

    localparam logic [LEN_W-1:0] RST_LEN_C = clamp_len(LEN_W'(RST_LEN));

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               z_q, z_d;

    logic [MAX_LEN-1:0] hist, shift_hist, mask;
    logic [LEN_W-1:0]   fill, shift_fill;
    logic               shift, clr, hit;

    assign shift = in_valid && !cfg_load;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_q));
    end

    // Match is judged on the history as it will look after this edge's shift.
    assign hit = shift && (((shift_hist ^ pattern_q) & mask) == '0) && (shift_fill >= len_q);
    assign clr = cfg_load || (hit && (overlap_q == OVL_OFF));

    seq_det_hist #(.MAX_LEN(MAX_LEN)) u_hist (
        .clk          (clk),
        .reset        (reset),
        .shift_i      (shift),
        .clr_i        (clr),
        .bit_i        (in),
        .hist_o       (hist),
        .fill_o       (fill),
        .shift_hist_o (shift_hist),
        .shift_fill_o (shift_fill)
    );

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        z_d       = hit;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = clamp_len(cfg_len);
            overlap_d = cfg_overlap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN_C;
            overlap_q <= RST_OVERLAP;
            z_q       <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            z_q       <= z_d;
        end
    end

    assign z     = z_q;
    assign armed = (fill >= len_q);

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load)
            cnt_d = '0;
        else if (hit && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    logic unused_hist;
    assign unused_hist = ^hist;
`endif

`ifdef SEQ_DET_MATCH_CNT_EN
    logic unused_hist;
    assign unused_hist = ^hist;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: a bit-list reference model feeds an expected queue
// that is popped one cycle later against z, armed and (when enabled) the match counters.
module tb_seq_det_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               z, armed;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [15:0]        match_cnt;
    logic [1:0]         match_cnt2;
    logic               z2, armed2;
`endif

    always #5 clk = ~clk;

    seq_det_param dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in          (din),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_MATCH_CNT_EN
        .match_cnt   (match_cnt),
`endif
        .z           (z),
        .armed       (armed)
    );

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_param #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in          (din),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .match_cnt   (match_cnt2),
        .z           (z2),
        .armed       (armed2)
    );
`endif

    int n_vec = 0;
    int n_err = 0;

    // {cnt2[1:0], cnt[15:0], armed, z}
    logic [19:0] exp_q[$];

    // Reference model: valid bits received since the last clear, oldest first.
    logic        m_bits[$];
    logic [7:0]  m_pat;
    int          m_len;
    logic        m_ovl;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_clamp(input int l);
        if (l <= 1) return 1;
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    function automatic logic model_match();
        int sz = m_bits.size();
        if (sz < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (m_bits[sz - m_len + k] !== m_pat[m_len - 1 - k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_cycle(input logic rst, input logic v, input logic b, input logic ld,
                               input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        logic        ez;
        logic [19:0] e;
        reset = rst; in_valid = v; din = b; cfg_load = ld;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        ez = 1'b0;
        if (rst) begin
            m_bits.delete(); m_pat = 8'b0000_0110; m_len = 3; m_ovl = 1'b1;
            m_cnt = '0; m_cnt2 = '0;
        end else if (ld) begin
            m_bits.delete(); m_pat = pat; m_len = model_clamp(int'(len)); m_ovl = ovl;
            m_cnt = '0; m_cnt2 = '0;
        end else if (v) begin
            m_bits.push_back(b);
            if (model_match()) begin
                ez = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt++;
                if (m_cnt2 != 2'b11) m_cnt2++;
                if (!m_ovl) m_bits.delete();
            end
        end
        exp_q.push_back({m_cnt2, m_cnt, (m_bits.size() >= m_len), ez});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("z", {31'b0, z}, {31'b0, e[0]});
        check("armed", {31'b0, armed}, {31'b0, e[1]});
`ifdef SEQ_DET_MATCH_CNT_EN
        check("match_cnt", {16'b0, match_cnt}, {16'b0, e[17:2]});
        check("match_cnt_sat", {30'b0, match_cnt2}, {30'b0, e[19:18]});
`endif
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic send(input logic v, input logic b);
        drive_cycle(1'b0, v, b, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, pat, len, ovl);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i]);
    endtask

    initial begin
        #1;
        do_reset();
        do_reset();

        // Default "110": stream 0110110
        send_bits(16'b0110110, 7);

        // "11" overlapping, then non-overlapping
        load(8'b11, 4'd2, 1'b1);
        send_bits(16'b1111, 4);
        load(8'b11, 4'd2, 1'b0);
        send_bits(16'b1111, 4);

        // "101" with 3-cycle valid gaps
        load(8'b101, 4'd3, 1'b1);
        for (int i = 2; i >= 0; i--) begin
            logic [2:0] p = 3'b101;
            send(1'b1, p[i]);
            for (int g = 0; g < 3; g++) send(1'b0, $urandom_range(0, 1));
        end

        // Load colliding with final matching bit; len 0 clamps to 1
        load(8'b101, 4'd3, 1'b1);
        send_bits(16'b10, 2);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'b1, 4'd0, 1'b1);
        send_bits(16'b1010, 4);

        // Over-long len clamps to MAX_LEN
        load(8'hA5, 4'd15, 1'b0);
        send_bits(16'hA5A5, 16);

        // Reset mid-sequence
        do_reset();
        send_bits(16'b11, 2);
        do_reset();
        send_bits(16'b0110, 4);

        // Counter saturation run: "1" len 1, six matches
        load(8'b1, 4'd1, 1'b1);
        send_bits(16'b111111, 6);

        // Randomised configurations and streams
        for (int r = 0; r < 6; r++) begin
            load(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 60; c++)
                send(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        if (exp_q.size() != 0)
            check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial sequence detector, the next generation of the fixed "110" detector FSM. Pattern, pattern length and overlap mode are run-time programmable, up to MAX_LEN bits. The block adds an input-valid qualifier and a registered match pulse. It sits on a serial bit stream and feeds downstream framing/control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
RST_PATTERN, 8'b0000_0110, pattern loaded at reset (right-aligned)
RST_LEN, 3, pattern length loaded at reset (default detects "110")
RST_OVERLAP, 1, overlap mode at reset (1 = overlapping)
CNT_W, 16, match counter width (used only with the optional feature)

Ports:
clk  in  1  clock; all logic is on posedge clk
reset  in  1  synchronous, active-high reset
in_valid  in  1  qualifies in; bit is consumed on an edge where in_valid=1
in  in  1  serial data bit
cfg_load  in  1  one-cycle strobe that loads the configuration
cfg_pattern  in  MAX_LEN  new pattern, right-aligned; cfg_pattern[len-1] is the first bit received
cfg_len  in  LEN_W  new length; LEN_W = clog2(MAX_LEN+1)
cfg_overlap  in  1  new overlap mode
z  out  1  registered match pulse
armed  out  1  fill >= len (enough history held to match)
match_cnt  out  CNT_W  saturating match count; present only with SEQ_DET_MATCH_CNT_EN

Behaviour:
- Reset (synchronous, has priority over everything else): hist=0, fill=0, z=0, armed=0, match_cnt=0; pattern/len/overlap <= RST_* values.
- State: hist[MAX_LEN-1:0] shift register, new bit enters at LSB; fill saturates at MAX_LEN.
- Edge with in_valid=1 and no cfg_load: hist <= {hist[MAX_LEN-2:0], in}; fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the shifted value: (new_hist & mask) == (pattern & mask) AND new_fill >= len, where mask = low len bits set. z <= 1 on that edge. Latency: z is high in the cycle immediately after the edge that samples the final pattern bit.
- z is a single-cycle pulse; it is 0 on any edge without a match, including in_valid=0 edges.
- Overlap=1: history is kept after a match, so "1111" with pattern "11" gives 3 matches.
- Overlap=0: on a match, fill <= 0 (hist contents are don't-care), so "1111" with pattern "11" gives 2 matches.
- in_valid=0: hist and fill hold; z <= 0. Gaps in valid do not break a sequence.
- cfg_load=1: pattern/len/overlap load; hist <= 0; fill <= 0; z <= 0. Any in_valid bit on the same edge is discarded.
- cfg_len clamp at load: 0 or 1 -> 1; > MAX_LEN -> MAX_LEN. Pattern bits above len are ignored.
- armed = (fill >= len), registered alongside fill.
- Reset asserted mid-sequence: partial history is lost; detection restarts from an empty history.

Optional Feature:
SEQ_DET_MATCH_CNT_EN
- Defined: match_cnt increments on every edge that sets z=1 and saturates at all-ones. It is cleared by reset and by cfg_load.
- Undefined: the match_cnt port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg: LEN_W derivation function, overlap-mode constants (OVL_ON/OVL_OFF), default pattern/len constants.
- Sub-module seq_det_hist: shift register plus saturating fill counter, with shift/clear controls.
- Top-level seq_det_param: config registers, mask/compare, overlap control, z, armed and the optional counter.

Test Plan:
- Reset defaults, stream 0,1,1,0,1,1,0 (in_valid=1) -> z pulses after the 4th and 7th bits; armed=1 from the 3rd bit on.
- Load pattern "11", len 2, overlap=1; stream 1,1,1,1 -> z high after bits 2, 3 and 4; match_cnt=3.
- Same stream with overlap=0 -> z high after bits 2 and 4 only; match_cnt=2.
- Pattern "101", with in_valid low for 3 cycles between each bit -> a single z pulse after the final valid bit; z=0 throughout the gaps.
- cfg_load on the same edge as the final matching bit -> bit discarded, z=0, fill=0; loaded cfg_len=0 reads back as len 1.
- Reset asserted after "11" of "110", then "0" applied -> no match. With CNT_W=2, 5 matches -> match_cnt saturates at 3.
